// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, opcodes, feeder states and opcode legality check
package cache_pkg;
  localparam int CMD_W = 36;
  localparam int ADDR_W = 32;
  localparam int OP_W = 4;
  typedef enum logic [OP_W-1:0] {
    OP_RD    = 4'd0,
    OP_WR    = 4'd1,
    OP_IF    = 4'd2,
    OP_INV   = 4'd3,
    OP_SNOOP = 4'd4,
    OP_CLR   = 4'd8,
    OP_PRINT = 4'd9
  } op_e;
  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_FLUSH, ST_DONE} feeder_state_e;
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op inside {OP_RD, OP_WR, OP_IF, OP_INV, OP_SNOOP, OP_CLR, OP_PRINT};
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: circular command buffer with a registered head word
module cmd_fifo import cache_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int W = CMD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic [W-1:0] r_head;
  logic [AW-1:0] w_rp_n;
  logic [AW:0] w_cnt_n;
  logic w_do_push, w_do_pop;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_head = r_head;
  assign w_do_pop = i_pop && !o_empty;
  assign w_do_push = i_push && !o_full;
  assign w_rp_n = r_rp + AW'(w_do_pop);
  assign w_cnt_n = r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
  always_ff @(posedge clk)
    if (w_do_push) r_mem[r_wp] <= i_wdata;
  // The head register tracks the entry at the next read pointer; a word written
  // into a FIFO that is about to be empty bypasses the memory.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_head <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + AW'(1);
      r_rp <= w_rp_n;
      r_cnt <= w_cnt_n;
      r_head <= (w_cnt_n == '0) ? '0 :
                (w_do_push && r_cnt == (AW+1)'(w_do_pop)) ? i_wdata : r_mem[w_rp_n];
    end
endmodule

// File: rtl/trace_feeder.sv
// trace_feeder: filters trace commands, queues them to the cache and closes with a print
module trace_feeder import cache_pkg::*; #(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CMD_W-1:0]  in_cmd,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CMD_W-1:0]  out_cmd,
  output logic [31:0]       issued_cnt,
  output logic [15:0]       drop_cnt,
  output logic              done
);
  feeder_state_e r_state, w_state_n;
  logic [31:0] r_issued;
  logic [15:0] r_drop;
  logic [ADDR_W-1:0] r_last_addr;
  logic [CMD_W-1:0] w_head;
  logic w_full, w_empty, w_in_hs, w_legal, w_push, w_pop;
  assign w_legal = op_legal(in_cmd[CMD_W-1:ADDR_W]);
  assign w_in_hs = in_valid && in_ready;
  assign w_push = w_in_hs && w_legal;
  assign w_pop = out_ready && !w_empty;
  assign in_ready = r_state == ST_RUN && !w_full;
  assign out_valid = r_state == ST_FLUSH || !w_empty;
  assign out_cmd = r_state == ST_FLUSH ? {OP_PRINT, r_last_addr} : w_head;
  assign issued_cnt = r_issued;
  assign drop_cnt = r_drop;
  assign done = r_state == ST_DONE;
  cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk(clk),
    .rst_n(reset_n),
    .i_push(w_push),
    .i_wdata(in_cmd),
    .i_pop(w_pop),
    .o_head(w_head),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_IDLE:  w_state_n = ST_RUN;
      ST_RUN:   w_state_n = (w_in_hs && in_last) ? ST_DRAIN : ST_RUN;
      ST_DRAIN: w_state_n = w_empty ? ST_FLUSH : ST_DRAIN;
      ST_FLUSH: w_state_n = out_ready ? ST_DONE : ST_FLUSH;
      default:  w_state_n = r_state;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_issued <= '0;
      r_drop <= '0;
      r_last_addr <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_pop) r_issued <= r_issued + 32'd1;
      if (w_in_hs && !w_legal && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      if (w_push) r_last_addr <= in_cmd[ADDR_W-1:0];
    end
endmodule

// File: tb/tb_trace_feeder.sv
// tb_trace_feeder: random and directed traces against a queue-based reference of the feeder
module tb_trace_feeder;
  localparam int DEPTH = 8;
  logic clk = 0, reset_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic in_ready, out_valid, done;
  logic [35:0] in_cmd = '0, out_cmd;
  logic [31:0] issued_cnt;
  logic [15:0] drop_cnt;
  int checks = 0, fails = 0, acc_held = 0;
  logic rdy_held = 0;
  trace_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_cmd(out_cmd), .issued_cnt(issued_cnt), .drop_cnt(drop_cnt), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic bit legal(input logic [3:0] op);
    logic [15:0] m = 16'h031F;
    return m[op];
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 0);
    chk({tag, "_out_valid"}, 64'(out_valid), 0);
    chk({tag, "_out_cmd"}, 64'(out_cmd), 0);
    chk({tag, "_issued"}, 64'(issued_cnt), 0);
    chk({tag, "_drop"}, 64'(drop_cnt), 0);
    chk({tag, "_done"}, 64'(done), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; in_valid = 0; in_last = 0; in_cmd = '0; out_ready = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask
  task automatic run_trace(input string tag, input logic [35:0] cmds[$], input int rdy_pct, input int hold);
    logic [35:0] exp_q[$];
    logic [35:0] prev = '0;
    logic [31:0] la = '0;
    logic stalled = 0;
    int drops = 0, idx = 0, got = 0;
    foreach (cmds[i])
      if (legal(cmds[i][35:32])) begin
        exp_q.push_back(cmds[i]);
        la = cmds[i][31:0];
      end else drops++;
    exp_q.push_back({4'h9, la});
    for (int cyc = 0; ; cyc++) begin
      @(negedge clk);
      if (done) break;
      if (cyc == 4000) begin
        chk({tag, "_timeout"}, 64'(done), 1);
        break;
      end
      in_valid = idx < cmds.size();
      in_cmd = in_valid ? cmds[idx] : '0;
      in_last = idx == cmds.size() - 1;
      out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
      #1;
      if (cyc == hold && hold > 0) begin
        acc_held = idx;
        rdy_held = in_ready;
      end
      if (stalled) begin
        chk({tag, "_stall_valid"}, 64'(out_valid), 1);
        chk({tag, "_stall_cmd"}, 64'(out_cmd), 64'(prev));
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        if (got < exp_q.size()) chk({tag, "_out_cmd"}, 64'(out_cmd), 64'(exp_q[got]));
        else chk({tag, "_extra_out"}, 64'(got + 1), 64'(exp_q.size()));
        got++;
      end
      stalled = out_valid && !out_ready;
      prev = out_cmd;
    end
    in_valid = 0; in_last = 0; out_ready = 0;
    #1;
    chk({tag, "_out_count"}, 64'(got), 64'(exp_q.size()));
    chk({tag, "_issued"}, 64'(issued_cnt), 64'(exp_q.size() - 1));
    chk({tag, "_drop"}, 64'(drop_cnt), 64'(drops));
    chk({tag, "_done"}, 64'(done), 1);
    chk({tag, "_done_out_valid"}, 64'(out_valid), 0);
    chk({tag, "_done_in_ready"}, 64'(in_ready), 0);
  endtask
  initial begin
    logic [35:0] q[$];
    logic [3:0] ops[7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};
    #1;
    chk_zero("por");
    do_reset();
    q = '{{4'h0, 32'h1000}, {4'h1, 32'h2000}, {4'h2, 32'h3000}};
    run_trace("basic", q, 100, 0);
    do_reset();
    q = '{{4'h5, 32'hAAAA}, {4'h1, 32'h40}};
    run_trace("drop_one", q, 100, 0);
    do_reset();
    q = '{{4'h7, 32'h55}};
    run_trace("only_illegal", q, 100, 0);
    do_reset();
    q = {};
    for (int i = 0; i < 10; i++) q.push_back({4'h1, 32'h100 + 32'(i)});
    run_trace("backpress", q, 100, 30);
    chk("backpress_accepted", 64'(acc_held), DEPTH);
    chk("backpress_in_ready", 64'(rdy_held), 0);
    do_reset();
    q = {};
    for (int i = 0; i < 50; i++) q.push_back({ops[$urandom_range(0, 6)], 32'($urandom)});
    run_trace("rand_stall", q, 50, 0);
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_last = 0; in_cmd = {4'h1, 32'(i)};
      @(negedge clk);
    end
    #1;
    chk("pre_reset_out_valid", 64'(out_valid), 1);
    chk("pre_reset_issued", 64'(issued_cnt), 0);
    #1 reset_n = 0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    reset_n = 1; in_valid = 0;
    @(negedge clk);
    #1;
    chk("post_reset_run", 64'(in_ready), 1);
    q = {};
    for (int i = 0; i < 30; i++) q.push_back({4'($urandom_range(0, 15)), 32'($urandom)});
    run_trace("rand_mixed", q, 60, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
